// File: rtl/rice_pkg.sv
// rtl/rice_pkg.sv - shared types, default parameters and width helpers for the rice block decoder
//   state_t : decoder FSM states
//   bufw()  : bit buffer width (two words)
//   jw()    : sample counter width for a given JMAX
//   fillw() : fill counter width (0..BUFW)
//   fsw()   : FS accumulator width, wide enough for FS_MAX plus one full buffer
package rice_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FS,
        SPLIT,
        EMIT,
        ERR
    } state_t;

    localparam int W_DEF      = 32;
    localparam int KW_DEF     = 5;
    localparam int SW_DEF     = 16;
    localparam int JMAX_DEF   = 64;
    localparam int FS_MAX_DEF = 255;

    function automatic int bufw(input int w);
        return 2 * w;
    endfunction

    function automatic int jw(input int jmax);
        return $clog2(jmax + 1);
    endfunction

    function automatic int fillw(input int w);
        return $clog2(2 * w + 1);
    endfunction

    function automatic int fsw(input int fs_max, input int w);
        return $clog2(fs_max + 2 * w + 1);
    endfunction

endpackage

// File: rtl/rice_block_decoder_if.sv
// rtl/rice_block_decoder_if.sv - bitstream input and sample output handshakes of the rice decoder
//   in_data/in_valid/in_ready            : packed word stream, MSB first
//   out_sample/out_valid/out_ready/out_last : decoded sample stream
//   slave  : decoder side
//   master : producer/consumer side
interface rice_block_decoder_if #(
    parameter int W  = 32,
    parameter int SW = 16
) ();
    logic [W-1:0]  in_data;
    logic          in_valid;
    logic          in_ready;
    logic [SW-1:0] out_sample;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_sample, out_valid, out_last
    );

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_sample, out_valid, out_last
    );
endinterface

// File: rtl/rice_lzc.sv
// rtl/rice_lzc.sv - masked leading-zero counter over the left-aligned bit buffer
//   data  : buffer, bit BUFW-1 is the oldest bit
//   fill  : number of valid bits from the top; lower bits are ignored
//   pos   : index (from the top) of the first 1 among the valid bits
//   found : a 1 exists among the valid bits
module rice_lzc
    import rice_pkg::*;
#(
    parameter int BUFW = bufw(W_DEF),
    parameter int FW   = fillw(W_DEF)
) (
    input  logic [BUFW-1:0] data,
    input  logic [FW-1:0]   fill,
    output logic [FW-1:0]   pos,
    output logic            found
);

    // Scan from the bottom upwards so the topmost qualifying 1 wins.
    always_comb begin
        pos   = '0;
        found = 1'b0;
        for (int i = BUFW - 1; i >= 0; i--) begin
            if (data[BUFW-1-i] && (i < int'(fill))) begin
                pos   = FW'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rice_block_decoder.sv
// rtl/rice_block_decoder.sv - streaming Rice decoder, J samples of (fs << k) | split per block
//   clk, reset : clock, asynchronous active-high reset
//   start      : pulse, latches k and j (j == 0 ignored) from IDLE or ERR
//   k, j       : split-bit count and samples per block
//   bus        : word input and sample output handshakes
//   busy       : block in progress
//   err_fs     : sticky FS overflow flag
module rice_block_decoder
    import rice_pkg::*;
#(
    parameter  int W      = W_DEF,
    parameter  int KW     = KW_DEF,
    parameter  int SW     = SW_DEF,
    parameter  int JMAX   = JMAX_DEF,
    parameter  int FS_MAX = FS_MAX_DEF,
    localparam int JW     = jw(JMAX)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [KW-1:0]        k,
    input  logic [JW-1:0]        j,
    rice_block_decoder_if.slave  bus,
    output logic                 busy,
    output logic                 err_fs
);

    localparam int BUFW = bufw(W);
    localparam int FW   = fillw(W);
    localparam int FSW  = fsw(FS_MAX, W);

    state_t          state_q, state_n;
    logic [BUFW-1:0] buf_q, buf_n;
    logic [FW-1:0]   fill_q, fill_n;
    logic [FSW-1:0]  fs_q, fs_n, fs_sum;
    logic [W-1:0]    split_q, split_n;
    logic [JW-1:0]   count_q, count_n, j_q, j_n;
    logic [KW-1:0]   k_q, k_n;
    logic            err_q, err_n;
    logic [FW-1:0]   consumed, lz_pos;
    logic            lz_found, flush, accept;
    logic [FSW+W-1:0] wide;

    rice_lzc #(.BUFW(BUFW), .FW(FW)) u_lzc (
        .data  (buf_q),
        .fill  (fill_q),
        .pos   (lz_pos),
        .found (lz_found)
    );

    assign busy          = (state_q != IDLE);
    assign err_fs        = err_q;
    assign bus.in_ready  = busy && (state_q != ERR) && (fill_q <= FW'(BUFW - W));
    assign accept        = bus.in_valid && bus.in_ready;
    assign bus.out_valid = (state_q == EMIT);
    assign bus.out_last  = (state_q == EMIT) && (count_q == j_q - JW'(1));
    assign wide          = ((FSW+W)'(fs_q) << k_q) | (FSW+W)'(split_q);
    assign bus.out_sample = (state_q == EMIT) ? SW'(wide) : '0;

    always_comb begin
        state_n  = state_q;
        fs_n     = fs_q;
        fs_sum   = fs_q;
        split_n  = split_q;
        count_n  = count_q;
        k_n      = k_q;
        j_n      = j_q;
        err_n    = err_q;
        consumed = '0;
        flush    = 1'b0;
        case (state_q)
            IDLE, ERR: begin
                if (start && (j != '0)) begin
                    k_n     = k;
                    j_n     = j;
                    fs_n    = '0;
                    split_n = '0;
                    count_n = '0;
                    err_n   = 1'b0;
                    flush   = 1'b1;
                    state_n = FS;
                end
            end
            FS: begin
                if (lz_found) begin
                    fs_sum   = fs_q + FSW'(lz_pos);
                    consumed = lz_pos + FW'(1);
                    state_n  = (k_q == '0) ? EMIT : SPLIT;
                end else begin
                    fs_sum   = fs_q + FSW'(fill_q);
                    consumed = fill_q;
                end
                fs_n = fs_sum;
                if (fs_sum > FSW'(FS_MAX)) begin
                    err_n   = 1'b1;
                    state_n = ERR;
                end
            end
            SPLIT: begin
                if (fill_q >= FW'(k_q)) begin
                    split_n  = W'(buf_q >> (FW'(BUFW) - FW'(k_q)));
                    consumed = FW'(k_q);
                    state_n  = EMIT;
                end
            end
            EMIT: begin
                if (bus.out_ready) begin
                    fs_n    = '0;
                    split_n = '0;
                    count_n = count_q + JW'(1);
                    if (count_q == j_q - JW'(1)) begin
                        flush   = 1'b1;
                        state_n = IDLE;
                    end else begin
                        state_n = FS;
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        // New word lands right behind whatever survives this cycle's consumption.
        if (flush) begin
            buf_n  = '0;
            fill_n = '0;
        end else begin
            buf_n  = (buf_q << consumed)
                   | (accept ? ({bus.in_data, {W{1'b0}}} >> (fill_q - consumed)) : '0);
            fill_n = fill_q - consumed + (accept ? FW'(W) : '0);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            buf_q   <= '0;
            fill_q  <= '0;
            fs_q    <= '0;
            split_q <= '0;
            count_q <= '0;
            k_q     <= '0;
            j_q     <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_n;
            buf_q   <= buf_n;
            fill_q  <= fill_n;
            fs_q    <= fs_n;
            split_q <= split_n;
            count_q <= count_n;
            k_q     <= k_n;
            j_q     <= j_n;
            err_q   <= err_n;
        end
    end

endmodule

// File: tb/tb_rice_block_decoder.sv
// tb/tb_rice_block_decoder.sv - directed self-checking bench for rice_block_decoder
module tb_rice_block_decoder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [4:0]  k = '0;
    logic [6:0]  j = '0;
    logic        busy;
    logic        err_fs;
    int          n_checks = 0;
    int          n_pass = 0;
    logic [31:0] wq[$];

    rice_block_decoder_if #(.W(32), .SW(16)) bus ();

    rice_block_decoder dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .k      (k),
        .j      (j),
        .bus    (bus),
        .busy   (busy),
        .err_fs (err_fs)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        bus.in_valid = (wq.size() > 0);
        bus.in_data  = (wq.size() > 0) ? wq[0] : 32'h0;
    end

    always @(posedge clk) begin
        if (bus.in_valid && bus.in_ready && wq.size() > 0)
            void'(wq.pop_front());
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic do_start(input logic [4:0] kk, input logic [6:0] jj);
        @(negedge clk);
        start = 1'b1;
        k     = kk;
        j     = jj;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!bus.out_valid && n < 60) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic expect_sample(input string tag, input logic [15:0] val, input logic last);
        wait_valid();
        check({tag, "_valid"}, bus.out_valid, 1);
        if (bus.out_valid) begin
            check({tag, "_sample"}, bus.out_sample, val);
            check({tag, "_last"}, bus.out_last, last);
        end
        @(negedge clk);
    endtask

    task automatic basic_block(input string tag);
        wq.push_back(32'h351C0000);
        do_start(5'd2, 7'd3);
        expect_sample({tag, "_s1"}, 16'd10, 1'b0);
        expect_sample({tag, "_s2"}, 16'd1, 1'b0);
        expect_sample({tag, "_s3"}, 16'd15, 1'b1);
        check({tag, "_busy_after"}, busy, 0);
    endtask

    initial begin
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_sample", bus.out_sample, 0);
        check("rst_out_last", bus.out_last, 0);
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_err_fs", err_fs, 0);
        reset = 1'b0;
        @(negedge clk);

        // j = 0 start is ignored
        do_start(5'd2, 7'd0);
        check("j0_busy", busy, 0);

        basic_block("basic");

        // k = 0 single sample: EMIT two cycles after FS entry
        wq.push_back(32'h80000000);
        do_start(5'd0, 7'd1);
        check("k0_fs_c0", bus.out_valid, 0);
        @(negedge clk);
        check("k0_fs_c1", bus.out_valid, 0);
        @(negedge clk);
        check("k0_emit_c2", bus.out_valid, 1);
        expect_sample("k0", 16'd0, 1'b1);

        // FS run crossing a word boundary
        wq.push_back(32'h00000000);
        wq.push_back(32'h80000000);
        do_start(5'd0, 7'd1);
        expect_sample("span", 16'd32, 1'b1);

        // Buffer over W bits blocks input; residue discarded at block end
        bus.out_ready = 1'b0;
        wq.push_back(32'h80000000);
        wq.push_back(32'hFFFFFFFF);
        do_start(5'd0, 7'd1);
        wait_valid();
        check("full_in_ready", bus.in_ready, 0);
        bus.out_ready = 1'b1;
        expect_sample("full", 16'd0, 1'b1);
        wq.push_back(32'h40000000);
        do_start(5'd0, 7'd1);
        expect_sample("fresh", 16'd1, 1'b1);

        // Backpressure on sample 2
        wq.push_back(32'h351C0000);
        do_start(5'd2, 7'd3);
        expect_sample("bp_s1", 16'd10, 1'b0);
        bus.out_ready = 1'b0;
        wait_valid();
        for (int c = 0; c < 5; c++) begin
            check("bp_hold_valid", bus.out_valid, 1);
            check("bp_hold_sample", bus.out_sample, 1);
            check("bp_hold_last", bus.out_last, 0);
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        expect_sample("bp_s2", 16'd1, 1'b0);
        expect_sample("bp_s3", 16'd15, 1'b1);

        // FS overflow: 8 zero words push fs to 256
        for (int i = 0; i < 8; i++) wq.push_back(32'h0);
        do_start(5'd0, 7'd1);
        for (int n = 0; n < 100 && !err_fs; n++) @(negedge clk);
        check("ovf_err_fs", err_fs, 1);
        repeat (3) @(negedge clk);
        check("ovf_err_hold", err_fs, 1);
        check("ovf_in_ready", bus.in_ready, 0);
        check("ovf_out_valid", bus.out_valid, 0);
        check("ovf_busy", busy, 1);
        wq.push_back(32'h351C0000);
        do_start(5'd2, 7'd3);
        check("ovf_err_clear", err_fs, 0);
        expect_sample("ovf_s1", 16'd10, 1'b0);
        expect_sample("ovf_s2", 16'd1, 1'b0);
        expect_sample("ovf_s3", 16'd15, 1'b1);

        // Reset while sample 2 is waiting in EMIT
        wq.push_back(32'h351C0000);
        do_start(5'd2, 7'd3);
        expect_sample("rmb_s1", 16'd10, 1'b0);
        bus.out_ready = 1'b0;
        wait_valid();
        reset = 1'b1;
        #1;
        check("rmb_out_valid", bus.out_valid, 0);
        check("rmb_out_sample", bus.out_sample, 0);
        check("rmb_out_last", bus.out_last, 0);
        check("rmb_busy", busy, 0);
        check("rmb_in_ready", bus.in_ready, 0);
        @(negedge clk);
        reset = 1'b0;
        wq.delete();
        bus.out_ready = 1'b1;
        basic_block("after_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
